sw_debounce: RTL and testbench



---
 rtl/sw_debounce.sv | 103 ++++++++++
 tb/tb_sw_debounce.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Per-bit 2-FF synchronizer and tick-sampled debouncer for the board slide switches.
// A bit's output flips only after STABLE_TICKS consecutive sample ticks disagree with it.
module sw_debounce #(
  parameter int WIDTH        = 16,
  parameter int CLK_DIV      = 100000,
  parameter int STABLE_TICKS = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] change_o,
  output logic             tick_o
);

  localparam int              CW       = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_chg;
  logic [CW-1:0]    r_cnt      [WIDTH];

  logic             w_tick;
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] w_chg_nxt;
  logic [CW-1:0]    w_cnt_nxt  [WIDTH];

  // in_i is asynchronous; only r_sync2 is ever read downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_i;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (CLK_DIV > 1) begin : g_presc
      localparam int            PW         = $clog2(CLK_DIV);
      localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
      logic [PW-1:0] r_presc;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_presc <= '0;
        end else if (r_presc == PRESC_LAST) begin
          r_presc <= '0;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end

      assign w_tick = (r_presc == PRESC_LAST);
    end else begin : g_no_presc
      // Dividing by one samples on every cycle.
      assign w_tick = 1'b1;
    end
  endgenerate

  always_comb begin
    w_out_nxt = r_out;
    w_chg_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_tick) begin
        if (r_sync2[i] == r_out[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          w_out_nxt[i] = r_sync2[i];
          w_chg_nxt[i] = 1'b1;
          w_cnt_nxt[i] = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out <= '0;
      r_chg <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_out <= w_out_nxt;
      r_chg <= w_chg_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign out_o    = r_out;
  assign change_o = r_chg;
  assign tick_o   = w_tick;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: a CLK_DIV=4/STABLE_TICKS=3 instance for the main scenarios
// and a CLK_DIV=1/STABLE_TICKS=1 instance for the minimum-latency case.
`timescale 1ns/1ps
module tb_sw_debounce;

  logic        clk;
  logic        rst;
  logic [15:0] in_v;
  logic [15:0] out_v;
  logic [15:0] chg_v;
  logic        tick_v;
  logic [15:0] f_in;
  logic [15:0] f_out;
  logic [15:0] f_chg;
  logic        f_tick;

  int tests_run;
  int tests_failed;
  int edge_n;

  sw_debounce #(.WIDTH(16), .CLK_DIV(4), .STABLE_TICKS(3)) u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .in_i     (in_v),
    .out_o    (out_v),
    .change_o (chg_v),
    .tick_o   (tick_v)
  );

  sw_debounce #(.WIDTH(16), .CLK_DIV(1), .STABLE_TICKS(1)) u_fast (
    .clk_i    (clk),
    .rst_i    (rst),
    .in_i     (f_in),
    .out_o    (f_out),
    .change_o (f_chg),
    .tick_o   (f_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic step_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic do_reset(input logic [15:0] v);
    rst  = 1'b1;
    in_v = v;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    edge_n = -1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    in_v = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (out_v !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_out: got %h expected %h", out_v, 16'h0000);
    end
    tests_run++;
    if (chg_v !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_change: got %h expected %h", chg_v, 16'h0000);
    end
    tests_run++;
    if (tick_v !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_tick: got %b expected %b", tick_v, 1'b0);
    end
    @(negedge clk);
    in_v   = 16'h0000;
    rst    = 1'b0;
    edge_n = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      tests_run++;
      if (tick_v !== (((k + 1) % 4) == 3)) begin
        tests_failed++;
        $display("FAIL tick_after_edge_%0d: got %b expected %b", k, tick_v, (((k + 1) % 4) == 3));
      end
    end
    tests_run++;
    if (out_v !== 16'h0000) begin
      tests_failed++;
      $display("FAIL idle_out: got %h expected %h", out_v, 16'h0000);
    end
  endtask

  task automatic test_single_bit();
    do_reset(16'h0001);
    step_to(10);
    tests_run++;
    if (out_v !== 16'h0000) begin
      tests_failed++;
      $display("FAIL single_out_e10: got %h expected %h", out_v, 16'h0000);
    end
    step_to(11);
    tests_run++;
    if (out_v !== 16'h0001) begin
      tests_failed++;
      $display("FAIL single_out_e11: got %h expected %h", out_v, 16'h0001);
    end
    tests_run++;
    if (chg_v !== 16'h0001) begin
      tests_failed++;
      $display("FAIL single_chg_e11: got %h expected %h", chg_v, 16'h0001);
    end
    step_to(12);
    tests_run++;
    if (chg_v !== 16'h0000 || out_v !== 16'h0001) begin
      tests_failed++;
      $display("FAIL single_e12: got out %h chg %h expected out 0001 chg 0000", out_v, chg_v);
    end
  endtask

  task automatic test_glitch();
    do_reset(16'h0001);
    step_to(4);
    in_v = 16'h0000;
    step_to(6);
    in_v = 16'h0001;
    step_to(11);
    tests_run++;
    if (out_v !== 16'h0000) begin
      tests_failed++;
      $display("FAIL glitch_out_e11: got %h expected %h", out_v, 16'h0000);
    end
    step_to(18);
    tests_run++;
    if (out_v !== 16'h0000 || chg_v !== 16'h0000) begin
      tests_failed++;
      $display("FAIL glitch_e18: got out %h chg %h expected out 0000 chg 0000", out_v, chg_v);
    end
    step_to(19);
    tests_run++;
    if (out_v !== 16'h0001 || chg_v !== 16'h0001) begin
      tests_failed++;
      $display("FAIL glitch_e19: got out %h chg %h expected out 0001 chg 0001", out_v, chg_v);
    end
  endtask

  // Runs straight on into the reset-mid-qualification scenario.
  task automatic test_multi_bit_and_reset();
    do_reset(16'h8421);
    step_to(10);
    tests_run++;
    if (out_v !== 16'h0000) begin
      tests_failed++;
      $display("FAIL multi_out_e10: got %h expected %h", out_v, 16'h0000);
    end
    step_to(11);
    tests_run++;
    if (out_v !== 16'h8421 || chg_v !== 16'h8421) begin
      tests_failed++;
      $display("FAIL multi_e11: got out %h chg %h expected out 8421 chg 8421", out_v, chg_v);
    end
    step_to(12);
    tests_run++;
    if (chg_v !== 16'h0000) begin
      tests_failed++;
      $display("FAIL multi_chg_e12: got %h expected %h", chg_v, 16'h0000);
    end
    in_v = 16'h0421;
    step_to(22);
    tests_run++;
    if (out_v !== 16'h8421) begin
      tests_failed++;
      $display("FAIL fall_out_e22: got %h expected %h", out_v, 16'h8421);
    end
    step_to(23);
    tests_run++;
    if (out_v !== 16'h0421 || chg_v !== 16'h8000) begin
      tests_failed++;
      $display("FAIL fall_e23: got out %h chg %h expected out 0421 chg 8000", out_v, chg_v);
    end
    step_to(24);
    tests_run++;
    if (chg_v !== 16'h0000) begin
      tests_failed++;
      $display("FAIL fall_chg_e24: got %h expected %h", chg_v, 16'h0000);
    end
    // bit 3 rises; ticks at edges 27 and 31 count, reset lands before edge 35
    in_v = 16'h0429;
    step_to(32);
    tests_run++;
    if (out_v !== 16'h0421) begin
      tests_failed++;
      $display("FAIL midqual_out_e32: got %h expected %h", out_v, 16'h0421);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_v !== 16'h0000 || chg_v !== 16'h0000) begin
      tests_failed++;
      $display("FAIL async_reset: got out %h chg %h expected out 0000 chg 0000", out_v, chg_v);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    edge_n = -1;
    step_to(10);
    tests_run++;
    if (out_v !== 16'h0000) begin
      tests_failed++;
      $display("FAIL requal_out_e10: got %h expected %h", out_v, 16'h0000);
    end
    step_to(11);
    tests_run++;
    if (out_v !== 16'h0429 || chg_v !== 16'h0429) begin
      tests_failed++;
      $display("FAIL requal_e11: got out %h chg %h expected out 0429 chg 0429", out_v, chg_v);
    end
  endtask

  task automatic test_fast_latency();
    logic [15:0] vals [4];
    logic [15:0] prev;
    vals[0] = 16'hA5A5;
    vals[1] = 16'h5A5A;
    vals[2] = 16'hFFFF;
    vals[3] = 16'h0000;
    prev    = 16'h0000;
    step();
    tests_run++;
    if (f_tick !== 1'b1 || f_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL fast_idle: got tick %b out %h expected tick 1 out 0000", f_tick, f_out);
    end
    for (int j = 0; j < 4; j++) begin
      f_in = vals[j];
      for (int e = 1; e <= 2; e++) begin
        step();
        tests_run++;
        if (f_out !== prev || f_chg !== 16'h0000) begin
          tests_failed++;
          $display("FAIL fast_hold_%0d_%0d: got out %h chg %h expected out %h chg 0000", j, e, f_out, f_chg, prev);
        end
      end
      step();
      tests_run++;
      if (f_out !== vals[j] || f_chg !== (prev ^ vals[j])) begin
        tests_failed++;
        $display("FAIL fast_accept_%0d: got out %h chg %h expected out %h chg %h", j, f_out, f_chg, vals[j], prev ^ vals[j]);
      end
      step();
      tests_run++;
      if (f_chg !== 16'h0000) begin
        tests_failed++;
        $display("FAIL fast_pulse_end_%0d: got %h expected %h", j, f_chg, 16'h0000);
      end
      prev = vals[j];
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    edge_n       = 0;
    rst          = 1'b1;
    in_v         = 16'h0000;
    f_in         = 16'h0000;
    test_reset();
    test_single_bit();
    test_glitch();
    test_multi_bit_and_reset();
    test_fast_latency();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
